// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM encoding,
// ROM access sizes and the instruction width helpers.
package instruction_fetch_buffer_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [1:0] ROM_SIZE_BYTE  = 2'b00;
    localparam logic [1:0] ROM_SIZE_HALF  = 2'b01;
    localparam logic [1:0] ROM_SIZE_WORD  = 2'b10;
    localparam logic [1:0] ROM_SIZE_DWORD = 2'b11;

    localparam int INSTR_BYTES = 4;

    // Pick one 32-bit instruction out of a little-endian 64-bit line.
    function automatic logic [31:0] select_word(input logic [63:0] line, input logic upper);
        return upper ? line[63:32] : line[31:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: requests a 64-bit line from the ROM, buffers it and issues
// its two 32-bit instructions to decode over a valid/ready handshake.
// Handshake: a transfer happens in every cycle where instr_valid and
// instr_ready are both high at the rising clock edge; while instr_valid is
// high and no transfer, branch or reset occurs, instr and instr_pc hold.
module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic [1:0]            rom_size,
    input  logic [63:0]           rom_data,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output fetch_state_t          state
);

    localparam int TAG_WIDTH = ADDR_WIDTH - 3;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_INIT   = RESET_PC & WORD_MASK;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [63:0]           line_q, line_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  line_valid_q, line_valid_d;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic                  same_line_hit;

    assign target_aligned = branch_target & WORD_MASK;
    assign same_line_hit  = (state_q == S_ISSUE) && line_valid_q &&
                            (target_aligned[ADDR_WIDTH-1:3] == tag_q);

    assign rom_address = {pc_q[ADDR_WIDTH-1:3], 3'b000};
    assign rom_size    = ROM_SIZE_DWORD;
    assign instr_pc    = pc_q;
    assign instr       = (state_q == S_ISSUE) ? select_word(line_q, pc_q[2]) : 32'd0;
    assign state       = state_q;

    // State, PC and line buffer registers; reset drops any in-flight fetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= PC_INIT;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            line_q       <= line_d;
            tag_q        <= tag_d;
            line_valid_q <= line_valid_d;
        end
    end

    // Next-state logic: sequential fetch/issue, with branch redirect overriding it.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        line_d       = line_q;
        tag_d        = tag_q;
        line_valid_d = line_valid_q;
        instr_valid  = 1'b0;

        case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                line_d       = rom_data;
                tag_d        = pc_q[ADDR_WIDTH-1:3];
                line_valid_d = 1'b1;
                state_d      = S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_d = pc_q + ADDR_WIDTH'(INSTR_BYTES);
                    if (pc_q[2]) begin
                        // Upper word consumed: the line has nothing left to give.
                        line_valid_d = 1'b0;
                        state_d      = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // A redirect wins over any sequential update, including a coincident transfer.
        if (branch_taken) begin
            pc_d = target_aligned;
            if (same_line_hit) begin
                line_valid_d = 1'b1;
                state_d      = S_ISSUE;
            end else begin
                line_valid_d = 1'b0;
                state_d      = S_REQ;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Bench for instruction_fetch_buffer with a behavioural 64-bit ROM whose
// word at byte address A is 32'hA0A0_0000 + A.
module tb_instruction_fetch_buffer;
    import instruction_fetch_buffer_pkg::*;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0]   rom_address;
    logic [1:0]   rom_size;
    logic [63:0]  rom_data;
    logic [31:0]  instr;
    logic [7:0]   instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         branch_taken;
    logic [7:0]   branch_target;
    fetch_state_t state;

    instruction_fetch_buffer #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_address   (rom_address),
        .rom_size      (rom_size),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .state         (state)
    );

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return 32'hA0A0_0000 + {24'd0, a};
    endfunction

    // ROM model: data for the presented address appears one cycle later.
    always @(posedge clock) begin
        rom_data <= {rom_word(rom_address + 8'd4), rom_word(rom_address)};
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // scoreboard: every accepted instruction must match the next expected PC
    always @(negedge clock) begin
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xfer", {56'd0, instr_pc}, 64'hFFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("xfer_pc", {56'd0, instr_pc}, {56'd0, e});
                check("xfer_instr", {32'd0, instr}, {32'd0, rom_word(e)});
            end
        end
    end

    // driver tasks: inputs change just after the rising edge, checks at the falling edge
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic push_range(input logic [7:0] first, input logic [7:0] last);
        logic [7:0] a;
        a = first;
        exp_q.push_back(a);
        while (a != last) begin
            a = a + 8'd4;
            exp_q.push_back(a);
        end
    endtask

    task automatic wait_issue(input logic [7:0] pc, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            mid();
            if (instr_valid && instr_pc == pc) begin
                found = 1'b1;
                break;
            end
            next_cycle();
        end
        check($sformatf("wait_issue_%02h", pc), {63'd0, found}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_pc;
        reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        next_cycle();
        next_cycle();

        // reset values, then sequential start of line 0 (cycle 0 below)
        reset = 1'b0; instr_ready = 1'b1;
        push_range(8'h00, 8'h04);
        mid();
        check("rst_state", state, S_REQ);
        check("rst_rom_address", rom_address, 8'h00);
        check("rst_rom_size", rom_size, 2'b11);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 8'h00);
        next_cycle(); mid();
        check("c1_state", state, S_WAIT);
        check("c1_valid", instr_valid, 1'b0);
        next_cycle(); mid();
        check("c2_valid", instr_valid, 1'b1);
        check("c2_instr", instr, 32'hA0A0_0000);
        next_cycle(); mid();
        check("c3_instr_pc", instr_pc, 8'h04);
        check("c3_instr", instr, 32'hA0A0_0004);
        next_cycle();
        instr_ready = 1'b0;
        mid();
        check("c4_rom_address", rom_address, 8'h08);
        check("c4_state", state, S_REQ);

        // stall handling: take 0x08/0x0C, then hold at 0x10 for 5 cycles
        wait_issue(8'h08, 10);
        next_cycle();
        instr_ready = 1'b1;
        push_range(8'h08, 8'h0C);
        next_cycle();
        next_cycle();
        instr_ready = 1'b0;
        wait_issue(8'h10, 10);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); mid();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_pc", instr_pc, 8'h10);
            check("stall_instr", instr, 32'hA0A0_0010);
        end
        next_cycle();
        instr_ready = 1'b1;
        push_range(8'h10, 8'h14);
        mid();
        next_cycle(); mid();
        check("release_pc", instr_pc, 8'h14);

        // run to the top of the address space and wrap to 0
        next_cycle();
        push_range(8'h18, 8'hFC);
        wait_issue(8'hFC, 400);
        next_cycle();
        instr_ready = 1'b0;
        mid();
        check("wrap_rom_address", rom_address, 8'h00);
        check("wrap_state", state, S_REQ);
        next_cycle();
        next_cycle(); mid();
        check("wrap_valid", instr_valid, 1'b1);
        check("wrap_instr_pc", instr_pc, 8'h00);

        // same-line branch 0x40 -> 0x44 reuses the buffered line
        next_cycle();
        instr_ready = 1'b1;
        push_range(8'h00, 8'h3C);
        wait_issue(8'h3C, 200);
        next_cycle();
        instr_ready = 1'b0;
        wait_issue(8'h40, 10);
        next_cycle();
        branch_taken = 1'b1; branch_target = 8'h44;
        mid();
        check("br_same_pre_pc", instr_pc, 8'h40);
        next_cycle();
        branch_taken = 1'b0;
        mid();
        check("br_same_valid", instr_valid, 1'b1);
        check("br_same_pc", instr_pc, 8'h44);
        check("br_same_instr", instr, 32'hA0A0_0044);
        check("br_same_state", state, S_ISSUE);

        // transfer coincident with a far branch to 0x20, then redirect 0x83 while waiting on line 0x20
        next_cycle();
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
        exp_q.push_back(8'h44);
        mid();
        next_cycle();
        instr_ready = 1'b0; branch_taken = 1'b0;
        mid();
        check("br_far_state", state, S_REQ);
        check("br_far_rom_address", rom_address, 8'h20);
        check("br_far_valid", instr_valid, 1'b0);
        next_cycle();
        branch_taken = 1'b1; branch_target = 8'h83;
        mid();
        check("br_wait_state", state, S_WAIT);
        next_cycle();
        branch_taken = 1'b0;
        mid();
        check("br_wait_redirect_state", state, S_REQ);
        check("br_wait_rom_address", rom_address, 8'h80);
        check("br_wait_valid", instr_valid, 1'b0);
        next_cycle();
        next_cycle(); mid();
        check("br_wait_first_valid", instr_valid, 1'b1);
        check("br_wait_first_pc", instr_pc, 8'h80);
        check("br_wait_first_instr", instr, 32'hA0A0_0080);

        // reset beats a coincident branch and handshake
        next_cycle();
        reset = 1'b1; branch_taken = 1'b1; branch_target = 8'h44; instr_ready = 1'b1;
        next_cycle();
        reset = 1'b0; branch_taken = 1'b0; instr_ready = 1'b0;
        mid();
        check("mid_rst_state", state, S_REQ);
        check("mid_rst_valid", instr_valid, 1'b0);
        check("mid_rst_pc", instr_pc, 8'h00);
        check("mid_rst_rom_address", rom_address, 8'h00);

        // random back-pressure over a sequential stream
        exp_pc = 8'h00;
        for (int i = 0; i < 120; i++) begin
            next_cycle();
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_ready && instr_valid) begin
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 8'd4;
            end
        end
        next_cycle();
        instr_ready = 1'b0;
        mid();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
